// File: rtl/goc_pkg.sv
// Shared definitions for the golden/faulty compare unit.
//   - goc_state_e : run-controller FSM states
//   - GOC_*_WIDTH : default vector / counter widths
//   - sat_inc     : saturating increment for counters up to GOC_SAT_MAX_W bits
package goc_pkg;

    localparam int GOC_TV_WIDTH  = 69;
    localparam int GOC_RV_WIDTH  = 5;
    localparam int GOC_CNT_WIDTH = 32;
    localparam int GOC_SAT_MAX_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } goc_state_e;

    // Increment val, but hold it once the low 'width' bits are all ones.
    // Callers zero-extend their counter to 64 bits and truncate the result.
    function automatic logic [GOC_SAT_MAX_W-1:0] sat_inc(
        input logic [GOC_SAT_MAX_W-1:0] val,
        input int unsigned              width
    );
        logic [GOC_SAT_MAX_W-1:0] top;
        top = (width >= GOC_SAT_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        return ((val & top) == top) ? val : (val + 64'd1);
    endfunction

endpackage

// File: rtl/goc_result_cmp.sv
// Registered masked compare of golden vs faulty result vectors.
//   clk, rst       : clock, synchronous active-high reset
//   clr_i          : clears all results (new run accepted)
//   sample_i       : current cycle is a valid DUT cycle (ce=1, out of reset)
//   cyc_idx_i      : enabled-cycle index of the current DUT cycle
//   mask_i         : 1 = bit participates in the compare
//   rv_golden_i/rv_faulty_i : circuit results
//   err_flag_o, err_count_o, first_err_cycle_o, first_err_vec_o : run results
// Results of a sampled cycle are registered first and compared on the next clk.
module goc_result_cmp
    import goc_pkg::*;
#(
    parameter int RV_WIDTH  = GOC_RV_WIDTH,
    parameter int CNT_WIDTH = GOC_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 sample_i,
    input  logic [CNT_WIDTH-1:0] cyc_idx_i,
    input  logic [RV_WIDTH-1:0]  mask_i,
    input  logic [RV_WIDTH-1:0]  rv_golden_i,
    input  logic [RV_WIDTH-1:0]  rv_faulty_i,
    output logic                 err_flag_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    output logic [CNT_WIDTH-1:0] first_err_cycle_o,
    output logic [RV_WIDTH-1:0]  first_err_vec_o
);

    logic                 vld_q;
    logic [RV_WIDTH-1:0]  gold_q, fault_q;
    logic [CNT_WIDTH-1:0] idx_q;
    logic                 err_flag_q;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [CNT_WIDTH-1:0] first_cyc_q;
    logic [RV_WIDTH-1:0]  first_vec_q;

    logic [RV_WIDTH-1:0]  diff;
    logic                 mismatch;

    assign diff        = (gold_q ^ fault_q) & mask_i;
    assign mismatch    = vld_q && (|diff);
    assign err_count_d = CNT_WIDTH'(sat_inc(GOC_SAT_MAX_W'(err_count_q), $unsigned(CNT_WIDTH)));

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            vld_q       <= 1'b0;
            gold_q      <= '0;
            fault_q     <= '0;
            idx_q       <= '0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
            first_cyc_q <= '0;
            first_vec_q <= '0;
        end else begin
            vld_q <= sample_i;
            if (sample_i) begin
                gold_q  <= rv_golden_i;
                fault_q <= rv_faulty_i;
                idx_q   <= cyc_idx_i;
            end
            if (mismatch) begin
                err_count_q <= err_count_d;
                err_flag_q  <= 1'b1;
                // err_flag_q still low means this is the first mismatch of the run
                if (!err_flag_q) begin
                    first_cyc_q <= idx_q;
                    first_vec_q <= diff;
                end
            end
        end
    end

    assign err_flag_o        = err_flag_q;
    assign err_count_o       = err_count_q;
    assign first_err_cycle_o = first_cyc_q;
    assign first_err_vec_o   = first_vec_q;

endmodule

// File: rtl/goc_compare_unit.sv
// Run controller for a golden/faulty circuit pair.
//   clk, rst            : clock, synchronous active-high reset
//   start, run_len, cmp_mask : run request (sampled when IDLE/DONE)
//   tv_in/tv_valid/tv_ready  : host vector stream
//   tv_out, dut_rst_n, dut_ce: registered drive to both circuits
//   rv_golden, rv_faulty     : circuit results
//   busy, done               : run status (done is sticky)
//   err_flag, err_count, first_err_cycle, first_err_vec : compare results
// Sequence: RESET (circuits in reset, RST_CYCLES enabled cycles) -> RUN (one
// enabled cycle per accepted vector) -> DRAIN (DRAIN_CYCLES extra enabled
// cycles) -> one flush cycle for the last compare -> DONE.
module goc_compare_unit
    import goc_pkg::*;
#(
    parameter int TV_WIDTH     = GOC_TV_WIDTH,
    parameter int RV_WIDTH     = GOC_RV_WIDTH,
    parameter int CNT_WIDTH    = GOC_CNT_WIDTH,
    parameter int RST_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] run_len,
    input  logic [RV_WIDTH-1:0]  cmp_mask,
    input  logic [TV_WIDTH-1:0]  tv_in,
    input  logic                 tv_valid,
    output logic                 tv_ready,
    output logic [TV_WIDTH-1:0]  tv_out,
    output logic                 dut_rst_n,
    output logic                 dut_ce,
    input  logic [RV_WIDTH-1:0]  rv_golden,
    input  logic [RV_WIDTH-1:0]  rv_faulty,
    output logic                 busy,
    output logic                 done,
    output logic                 err_flag,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] first_err_cycle,
    output logic [RV_WIDTH-1:0]  first_err_vec
);

    localparam int PH_W = 32;
    localparam logic [PH_W-1:0] RST_LAST       = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] DRAIN_FULL     = PH_W'(DRAIN_CYCLES);
    // Entering DRAIN straight from RESET: the first drain cycle is already enabled.
    localparam logic [PH_W-1:0] DRAIN_FROM_RST = PH_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    goc_state_e           state_q;
    logic [TV_WIDTH-1:0]  tv_out_q;
    logic                 dut_rst_n_q, dut_ce_q, tv_ready_q, busy_q, done_q;
    logic [CNT_WIDTH-1:0] run_len_q, hs_cnt_q, cyc_cnt_q;
    logic [RV_WIDTH-1:0]  mask_q;
    logic [PH_W-1:0]      ph_cnt_q;   // RESET: cycles elapsed; DRAIN: enabled cycles left

    logic accept, hs, dut_vld;

    assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign hs      = tv_valid && tv_ready_q;
    assign dut_vld = dut_ce_q && dut_rst_n_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tv_out_q    <= '0;
            dut_rst_n_q <= 1'b0;
            dut_ce_q    <= 1'b0;
            tv_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            run_len_q   <= '0;
            mask_q      <= '0;
            hs_cnt_q    <= '0;
            ph_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_RESET;
                        run_len_q   <= run_len;
                        mask_q      <= cmp_mask;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        dut_rst_n_q <= 1'b0;
                        dut_ce_q    <= 1'b1;
                        hs_cnt_q    <= '0;
                        ph_cnt_q    <= '0;
                    end
                end
                ST_RESET: begin
                    if (ph_cnt_q == RST_LAST) begin
                        dut_rst_n_q <= 1'b1;
                        if (run_len_q == '0) begin
                            state_q  <= ST_DRAIN;
                            dut_ce_q <= (DRAIN_CYCLES != 0);
                            ph_cnt_q <= DRAIN_FROM_RST;
                        end else begin
                            state_q    <= ST_RUN;
                            dut_ce_q   <= 1'b0;
                            tv_ready_q <= 1'b1;
                        end
                    end else begin
                        ph_cnt_q <= ph_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Circuits only advance in the cycle after a handshake.
                    dut_ce_q <= hs;
                    if (hs) begin
                        tv_out_q <= tv_in;
                        hs_cnt_q <= hs_cnt_q + CNT_WIDTH'(1);
                        if (hs_cnt_q == run_len_q - CNT_WIDTH'(1)) begin
                            state_q    <= ST_DRAIN;
                            tv_ready_q <= 1'b0;
                            ph_cnt_q   <= DRAIN_FULL;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (dut_ce_q) begin
                        if (ph_cnt_q != '0) ph_cnt_q <= ph_cnt_q - 1'b1;
                        else                dut_ce_q <= 1'b0;
                    end else begin
                        // Flush cycle: the last enabled cycle's compare lands here.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Enabled-cycle index; 0 on the first valid DUT cycle of the run.
    always_ff @(posedge clk) begin
        if (rst || accept) cyc_cnt_q <= '0;
        else if (dut_vld)  cyc_cnt_q <= cyc_cnt_q + CNT_WIDTH'(1);
    end

    goc_result_cmp #(
        .RV_WIDTH  (RV_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cmp (
        .clk               (clk),
        .rst               (rst),
        .clr_i             (accept),
        .sample_i          (dut_vld),
        .cyc_idx_i         (cyc_cnt_q),
        .mask_i            (mask_q),
        .rv_golden_i       (rv_golden),
        .rv_faulty_i       (rv_faulty),
        .err_flag_o        (err_flag),
        .err_count_o       (err_count),
        .first_err_cycle_o (first_err_cycle),
        .first_err_vec_o   (first_err_vec)
    );

    assign tv_out    = tv_out_q;
    assign dut_rst_n = dut_rst_n_q;
    assign dut_ce    = dut_ce_q;
    assign tv_ready  = tv_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/goc_compare_unit.md
Name: goc_compare_unit

Overview:
- Parametrised run controller for a golden/faulty circuit pair.
- Streams host-supplied test vectors into both circuit instances in lock-step and drives their shared reset and clock-enable.
- Compares the two result vectors every enabled cycle under a mask.
- Reports mismatch count, first-mismatch cycle and first-mismatch bit pattern; sits between the host interface and the two circuit wrappers.

Parameters:
TV_WIDTH, 69, test vector width fed to both circuits
RV_WIDTH, 5, result vector width returned by each circuit
CNT_WIDTH, 32, width of run-length, cycle and error counters
RST_CYCLES, 4, cycles the circuits are held in reset at run start (>=1)
DRAIN_CYCLES, 16, extra enabled cycles after the last vector so pipelined results are compared (>=0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begins a run (ignored unless IDLE or DONE)
run_len  in  CNT_WIDTH  number of vectors in the run, sampled on accepted start
cmp_mask  in  RV_WIDTH  1 = bit compared; sampled on accepted start
tv_in  in  TV_WIDTH  host test vector
tv_valid  in  1  tv_in valid
tv_ready  out  1  tv_in accepted when tv_valid&tv_ready
tv_out  out  TV_WIDTH  registered vector to both circuits
dut_rst_n  out  1  active-low circuit reset, registered
dut_ce  out  1  circuit clock enable, registered
rv_golden  in  RV_WIDTH  golden circuit result
rv_faulty  in  RV_WIDTH  faulty circuit result
busy  out  1  run in progress
done  out  1  sticky, run complete until next start or rst
err_flag  out  1  at least one mismatch in current run
err_count  out  CNT_WIDTH  mismatching cycles, saturates at all-ones
first_err_cycle  out  CNT_WIDTH  enabled-cycle index (from 0) of first mismatch
first_err_vec  out  RV_WIDTH  (rv_golden ^ rv_faulty) & mask at first mismatch

Behaviour:
- Reset (rst=1): state IDLE. Outputs: tv_out=0, dut_rst_n=0, dut_ce=0, tv_ready=0, busy=0, done=0, err_flag=0, err_count=0, first_err_cycle=0, first_err_vec=0. Internal counters cleared. rst mid-run aborts immediately; no partial results are retained.
- FSM:
  - IDLE/DONE --start--> RESET. On accept: latch run_len and cmp_mask; clear err_*, first_err_*, cycle counter; done=0; busy=1.
  - RESET: dut_rst_n=0, dut_ce=1 for exactly RST_CYCLES cycles, then RUN (dut_rst_n=1 from the first RUN cycle).
  - RUN: tv_ready=1. Each handshake loads tv_out and asserts dut_ce for the following cycle. No handshake: dut_ce=0 and tv_out holds, so both circuits freeze. After run_len handshakes, go to DRAIN.
  - run_len=0: RESET goes directly to DRAIN.
  - DRAIN: tv_ready=0, tv_out holds the last vector, dut_ce=1 for DRAIN_CYCLES cycles, then DONE.
  - DONE: busy=0, done=1, dut_ce=0, dut_rst_n=1. Results stable until next start.
- Compare pipeline:
  - rv_golden/rv_faulty are registered on every cycle in which dut_ce was 1 and dut_rst_n was 1 (DUT-cycle valid). The compare happens on the next clk.
  - mismatch = |((g^f)&mask).
  - On mismatch: err_count+1 (saturating); err_flag=1. On the first mismatch only, capture first_err_cycle (the enabled-cycle counter value of that DUT cycle) and first_err_vec.
  - The enabled-cycle counter increments only on valid DUT cycles and starts at 0 on the first RUN DUT cycle.
  - The compare of the final DRAIN cycle completes before done rises (done latency = 1 cycle after the last DRAIN cycle).
- start during RESET/RUN/DRAIN: ignored.
- start coincident with rst: rst wins.
- tv_valid asserted outside RUN: not consumed.
- cmp_mask=0: no errors are ever counted.

Decomposition:
- Package goc_pkg: FSM state enum (IDLE, RESET, RUN, DRAIN, DONE); default widths TV_WIDTH/RV_WIDTH/CNT_WIDTH; saturating-increment function.
- One sub-module, goc_result_cmp: registered masked compare, saturating error counter, first-error capture. The FSM stays in goc_compare_unit.

Test Plan:
- RST_CYCLES=4, DRAIN_CYCLES=2, run_len=3, tv_valid always 1, rv_faulty=rv_golden -> dut_rst_n low exactly 4 cycles; 3 handshakes; dut_ce high 4+3+2 cycles; done 1 cycle after the last DRAIN cycle; err_count=0, err_flag=0.
- Same run, rv_faulty differs in bit 2 only on enabled cycle 1, mask=5'b11111 -> err_count=1, first_err_cycle=1, first_err_vec=5'b00100.
- Mismatch only in bit 2, mask=5'b11011 -> err_count=0, err_flag=0.
- run_len=4 with tv_valid low for 3 cycles between vectors 2 and 3 -> dut_ce low for those 3 cycles; tv_out holds vector 2; first_err_cycle indices unaffected by the stall.
- CNT_WIDTH=4, persistent mismatch over 20 enabled cycles -> err_count saturates at 15; first_err_cycle=0.
- rst asserted mid-RUN, then new start with run_len=0 -> all outputs return to reset values; second run goes RESET->DRAIN->DONE with no handshakes.
